// File: rtl/rf_multiport.sv
// Multi-port register file: NUM_RD read ports, two prioritized write ports,
// clear sequencer after reset. Optional write trace under RF_TRACE_EN.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  output logic                     rf_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                rf_ready_q, rf_ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                ok0, ok1;

  // Writes to entry 0 vanish entirely when it is hardwired.
  always_comb begin
    ok0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
    ok1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rf_ready_d = rf_ready_q;
    mem_d      = mem_q;
    unique case (state_q)
      CLEAR: begin
        mem_d[clr_idx_q] = '0;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = RUN;
          rf_ready_d = 1'b1;
        end
      end
      RUN: begin
        if (ok0) mem_d[wa0] = wd0;
        if (ok1) mem_d[wa1] = wd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      rf_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rf_ready_q <= rf_ready_d;
    end
  end

  // Storage is left alone while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) mem_q <= mem_d;
  end

  assign rf_ready = rf_ready_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1, zero;
    assign a    = ra[k*ADDR_W +: ADDR_W];
    assign hit1 = BYPASS != 0 && we1 && wa1 == a;
    assign hit0 = BYPASS != 0 && we0 && wa0 == a;
    assign zero = state_q != RUN || (ZERO_REG != 0 && a == '0);
    assign rd[k*DATA_W +: DATA_W] =
      zero ? '0 :
      hit1 ? wd1 :
      hit0 ? wd0 : mem_q[a];
  end

`ifdef RF_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && state_q == RUN) begin
      if (ok0) begin
        if (ok1 && wa1 == wa0)
          $display("rf: port0 x%0d dropped", wa0);
        else
          $display("rf: port%0d x%0d <= 0x%h", 0, wa0, wd0);
      end
      if (ok1)
        $display("rf: port%0d x%0d <= 0x%h", 1, wa1, wd1);
    end
  end
`else
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: default instance plus a small no-bypass,
// no-zero-reg, four-read-port instance, both checked against a model.
module tb_rf_multiport;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: defaults
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic        a_we0, a_we1, a_ready;
  logic [4:0]  a_wa0, a_wa1;
  logic [31:0] a_wd0, a_wd1;

  // instance B: ADDR_W=3, DATA_W=16, NUM_RD=4, ZERO_REG=0, BYPASS=0
  logic [11:0] b_ra;
  logic [63:0] b_rd;
  logic        b_we0, b_we1, b_ready;
  logic [2:0]  b_wa0, b_wa1;
  logic [15:0] b_wd0, b_wd1;

  rf_multiport u_a (
    .clk(clk), .rst_n(rst_n), .ra(a_ra), .rd(a_rd),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
    .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .rf_ready(a_ready)
  );

  rf_multiport #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(4),
    .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ra(b_ra), .rd(b_rd),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .rf_ready(b_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an entry array per instance and the number of clear edges seen.
  logic [31:0] ma [32];
  logic [15:0] mb [8];
  int  a_cnt = 0;
  int  b_cnt = 0;
  bit  started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      a_cnt = 0;
      b_cnt = 0;
      started = 1;
    end else if (started) begin
      if (a_cnt >= 32) begin
        if (a_we0 && a_wa0 != 0) ma[a_wa0] = a_wd0;
        if (a_we1 && a_wa1 != 0) ma[a_wa1] = a_wd1;
      end else begin
        a_cnt++;
        if (a_cnt == 32) foreach (ma[i]) ma[i] = '0;
      end
      if (b_cnt >= 8) begin
        if (b_we0) mb[b_wa0] = b_wd0;
        if (b_we1) mb[b_wa1] = b_wd1;
      end else begin
        b_cnt++;
        if (b_cnt == 8) foreach (mb[i]) mb[i] = '0;
      end
    end
  end

  function automatic logic [31:0] exp_a(input int k);
    logic [4:0] ad;
    ad = a_ra[k*5 +: 5];
    if (a_cnt < 32 || ad == 0) return '0;
    if (a_we1 && a_wa1 == ad) return a_wd1;
    if (a_we0 && a_wa0 == ad) return a_wd0;
    return ma[ad];
  endfunction

  function automatic logic [15:0] exp_b(input int k);
    logic [2:0] ad;
    ad = b_ra[k*3 +: 3];
    if (b_cnt < 8) return '0;
    return mb[ad];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("a_ready", {31'd0, a_ready}, {31'd0, a_cnt >= 32});
      chk("b_ready", {31'd0, b_ready}, {31'd0, b_cnt >= 8});
      for (int k = 0; k < 2; k++)
        chk($sformatf("a_rd%0d", k), a_rd[k*32 +: 32], exp_a(k));
      for (int k = 0; k < 4; k++)
        chk($sformatf("b_rd%0d", k), {16'd0, b_rd[k*16 +: 16]},
            {16'd0, exp_b(k)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we0 = 0; a_we1 = 0; b_we0 = 0; b_we1 = 0;
    a_wa0 = 0; a_wa1 = 0; a_wd0 = 0; a_wd1 = 0;
    b_wa0 = 0; b_wa1 = 0; b_wd0 = 0; b_wd1 = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!a_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    idle();
    a_ra = 0;
    b_ra = 0;
    rst_n = 0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_rd", a_rd[31:0], 32'd0);
    rst_n = 1;
    wait_ready(n);
    chk("clear_len", n, 32);
    chk("b_ready_lit", {31'd0, b_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      a_ra = {5'(i), 5'(i)};
      #2;
      chk("cleared", a_rd[31:0], 32'd0);
      tick();
    end

    // basic write: A bypasses, B does not
    a_we0 = 1; a_wa0 = 5; a_wd0 = 32'h12345678; a_ra = 10'd5;
    b_we0 = 1; b_wa0 = 5; b_wd0 = 16'h1234; b_ra = 12'd5;
    #2;
    chk("a_bypass", a_rd[31:0], 32'h12345678);
    chk("b_prewrite", {16'd0, b_rd[15:0]}, 32'd0);
    tick();
    idle();
    #2;
    chk("a_written", a_rd[31:0], 32'h12345678);
    chk("b_written", {16'd0, b_rd[15:0]}, 32'h1234);

    // same-address conflict
    a_we0 = 1; a_wa0 = 9; a_wd0 = 32'hAAAA0000;
    a_we1 = 1; a_wa1 = 9; a_wd1 = 32'h5555FFFF;
    a_ra = {5'd9, 5'd0};
    #2;
    chk("conflict_byp", a_rd[63:32], 32'h5555FFFF);
    tick();
    idle();
    a_ra = {5'd0, 5'd9};
    #2;
    chk("conflict_mem", a_rd[31:0], 32'h5555FFFF);

    // zero register
    a_we1 = 1; a_wa1 = 0; a_wd1 = 32'hFFFFFFFF; a_ra = 0;
    b_we1 = 1; b_wa1 = 0; b_wd1 = 16'hFFFF; b_ra = 0;
    #2;
    chk("zero_byp", a_rd[31:0], 32'd0);
    tick();
    idle();
    #2;
    chk("zero_after", a_rd[31:0], 32'd0);
    chk("b_x0", {16'd0, b_rd[15:0]}, 32'hFFFF);

    // four simultaneous reads
    b_we0 = 1; b_wa0 = 1; b_wd0 = 16'h0101;
    b_we1 = 1; b_wa1 = 2; b_wd1 = 16'h0202;
    tick();
    idle();
    b_we0 = 1; b_wa0 = 3; b_wd0 = 16'h0303;
    tick();
    idle();
    b_ra = {3'd1, 3'd3, 3'd2, 3'd1};
    #2;
    chk("quad0", {16'd0, b_rd[15:0]},  32'h0101);
    chk("quad1", {16'd0, b_rd[31:16]}, 32'h0202);
    chk("quad2", {16'd0, b_rd[47:32]}, 32'h0303);
    chk("quad3", {16'd0, b_rd[63:48]}, 32'h0101);

    // reset mid-RUN
    a_we0 = 1; a_wa0 = 3; a_wd0 = 32'h11;
    a_we1 = 1; a_wa1 = 7; a_wd1 = 32'hDEADBEEF;
    tick();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    a_ra = 10'd7;
    #2;
    chk("clear_rd7", a_rd[31:0], 32'd0);
    a_we0 = 1; a_wa0 = 4; a_wd0 = 32'h44;
    tick();
    idle();
    wait_ready(n);
    chk("reclear_len", n + 1, 32);
    a_ra = {5'd4, 5'd3};
    #2;
    chk("e3_cleared", a_rd[31:0], 32'd0);
    chk("e4_dropped", a_rd[63:32], 32'd0);

    // randomized traffic with resets in RUN and mid-CLEAR
    for (int c = 0; c < 600; c++) begin
      rst_n = !(c == 200 || c == 400 || c == 410);
      a_we0 = 1'($urandom); a_we1 = 1'($urandom);
      a_wa1 = 5'($urandom);
      a_wa0 = ($urandom_range(0, 3) == 0) ? a_wa1 : 5'($urandom);
      a_wd0 = $urandom; a_wd1 = $urandom;
      a_ra = {($urandom_range(0, 2) == 0) ? a_wa0 : 5'($urandom),
              ($urandom_range(0, 2) == 0) ? a_wa1 : 5'($urandom)};
      b_we0 = 1'($urandom); b_we1 = 1'($urandom);
      b_wa1 = 3'($urandom);
      b_wa0 = ($urandom_range(0, 3) == 0) ? b_wa1 : 3'($urandom);
      b_wd0 = 16'($urandom); b_wd1 = 16'($urandom);
      b_ra = 12'($urandom);
      tick();
    end
    idle();
    rst_n = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised successor to the single-write-port CPU register file. Provides NUM_RD combinational read ports, two write ports with fixed priority, an optional hardwired zero register, optional write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset. Sits in the decode stage; `rf_ready` gates instruction issue until the clear completes.

Parameters:
DATA_W, 32, entry width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a read of an address being written this cycle returns the write data

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ra  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
rf_ready  out  1  1 = clear finished, writes accepted, reads valid

Behaviour:
- Single clock `clk`. Reset `rst_n` is synchronous and active-low, sampled only on the rising edge of `clk`.
- Two-state FSM, CLEAR and RUN, with a clear index `clr_idx` of ADDR_W bits.
- Reset: at an edge with rst_n=0: state<=CLEAR, clr_idx<=0, rf_ready<=0. Storage is not touched during reset.
- CLEAR: each edge with rst_n=1 writes 0 to entry clr_idx and increments clr_idx. At the edge where clr_idx==DEPTH-1: state<=RUN, rf_ready<=1. rf_ready therefore rises exactly DEPTH edges after rst_n is first sampled high.
- CLEAR side effects: we0/we1 are ignored. All rd ports drive 0.
- Reset mid-CLEAR or mid-RUN: restarts from clr_idx=0. Entries already cleared stay cleared and are cleared again.
- RUN writes: on a rising edge, when weN=1, entry waN <= wdN. Write latency is 1 cycle.
- Same-address conflict: if we0 and we1 are both set and wa0==wa1, wd1 is written and wd0 is dropped. Different addresses are both written in the same cycle.
- Reads in RUN: combinational, no latency. rd[k] = entry ra[k].
- BYPASS=1: if we1 and wa1==ra[k], rd[k]=wd1. Else if we0 and wa0==ra[k], rd[k]=wd0. Else the stored value. Port 1 has priority, matching write priority.
- BYPASS=0: reads return the pre-edge stored value.
- ZERO_REG=1: writes to address 0 are discarded, including bypass. rd[k]=0 whenever ra[k]==0, in both states.
- ZERO_REG=0: entry 0 behaves like any other entry.
- Width rules: no sign or zero extension; DATA_W is passed through unchanged.
- Outputs after reset: rd = all zeros, rf_ready = 0.

Optional Feature:
Macro: RF_TRACE_EN
- Defined: a simulation-only `$display` on every committed RUN-state write, format "rf: port%0d x%0d <= 0x%h", one line per port. A dropped port-0 write on a same-address conflict prints "rf: port0 x%0d dropped". The ZERO_REG discard of a write to address 0 prints nothing. CLEAR-state writes print nothing.
- Undefined: no display statements are compiled. Functional behaviour is identical either way.

Test Plan:
- Clear sequence: default params, hold rst_n=0 for 3 edges, then release → rf_ready=0 for 32 edges, then 1. Every entry reads 0. Reads during CLEAR return 0 even after preloading entry 7 with 0xDEADBEEF before reset.
- Basic write/read: we0=1, wa0=5, wd0=0x12345678 for one edge → next cycle rd[0] with ra[0]=5 returns 0x12345678. Before that edge, with BYPASS=0, it returns 0.
- Conflict and bypass: we0=we1=1, wa0=wa1=9, wd0=0xAAAA0000, wd1=0x5555FFFF, ra[1]=9, BYPASS=1 → rd[1]=0x5555FFFF in the same cycle. Entry 9 holds 0x5555FFFF afterwards.
- Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF → rd with ra=0 returns 0 in the same cycle and after the edge. Repeat with ZERO_REG=0 → returns 0xFFFFFFFF after the edge.
- Reset mid-operation: write 0x11 to entry 3, wait until rf_ready=1, assert rst_n=0 for one edge, then release → rf_ready=0 for 32 edges. Entry 3 reads 0 after the clear. A write to entry 4 issued during CLEAR is absent afterwards.
- Parametric: ADDR_W=3, DATA_W=16, NUM_RD=4 → rf_ready rises after 8 edges. Four simultaneous reads of entries 1, 2, 3, 1 each return their written 16-bit values.
